// File: rtl/int_rf_wb_buffer_pkg.sv
// Shared types and defaults for the integer register-file write-back buffer.
//
// Contents:
//   XLEN, REG_IDX_LEN       datapath width and register index width
//   WB_DEPTH, WB_COMMIT_W   default FIFO depth and number of commit lanes
//   wb_entry_t              one queued RF write {rd_idx, value}
package int_rf_wb_buffer_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned REG_IDX_LEN = 5;

    localparam int unsigned WB_DEPTH    = 4;
    localparam int unsigned WB_COMMIT_W = 2;

    typedef struct packed {
        logic [REG_IDX_LEN-1:0] rd_idx;
        logic [XLEN-1:0]        value;
    } wb_entry_t;

endpackage

// File: rtl/int_rf_wb_buffer_byp_match.sv
// Priority match of one issue-stage register index against the pending
// entries of the write-back buffer.
//
// Entries are visited in age order starting at head_i for count_i entries,
// so a later match overrides an earlier one and the youngest pending write
// (closest to the tail) wins. Index 0 never matches.
//
// Ports:
//   idx_i        in   REG_IDX_LEN           register index to look up
//   entry_idx_i  in   DEPTH x REG_IDX_LEN   destination index of every slot
//   head_i       in   clog2(DEPTH)          slot of the oldest entry
//   count_i      in   clog2(DEPTH)+1        number of valid entries
//   sel_o        out  DEPTH                 one-hot slot of youngest match, or 0
module int_rf_wb_byp_match
    import int_rf_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic [REG_IDX_LEN-1:0]            idx_i,
    input  logic [DEPTH-1:0][REG_IDX_LEN-1:0] entry_idx_i,
    input  logic [$clog2(DEPTH)-1:0]          head_i,
    input  logic [$clog2(DEPTH):0]            count_i,
    output logic [DEPTH-1:0]                  sel_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] slot;

    always_comb begin
        sel_o = '0;
        slot  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_i + PTR_W'(i);
            if ((idx_i != '0) && (CNT_W'(i) < count_i) && (entry_idx_i[slot] == idx_i)) begin
                sel_o       = '0;
                sel_o[slot] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_rf_wb_buffer.sv
// Commit-side writer for the integer register file.
//
// Up to COMMIT_W retired results per cycle are queued in order into a
// DEPTH-entry FIFO and drained one per cycle into the single RF write port.
// Results targeting x0 are accepted but never stored. Pending entries are
// scanned for issue-stage operand reads (rs1, rs2) to report hits and,
// when INT_RF_WB_BYPASS_EN is defined, to forward the youngest pending value.
// With INT_RF_WB_BYPASS_EN undefined the value mux is not built and
// byp_*_value_o are tied to zero; hits still report so issue can stall.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   cm_valid_i      [COMMIT_W]      per-lane commit valid (lane 0 oldest)
//   cm_ready_o                      all lanes can be accepted this cycle
//   cm_rd_idx_i     [COMMIT_W*5]    per-lane destination index
//   cm_rd_value_i   [COMMIT_W*XLEN] per-lane result
//   rf_valid_o, rf_rd_idx_o,
//   rf_rd_value_o                   RF write port (head of FIFO)
//   issue_rs1_idx_i, issue_rs2_idx_i  issue-stage operand indices
//   byp_rs1_hit_o, byp_rs2_hit_o      operand has a pending write
//   byp_rs1_value_o, byp_rs2_value_o  youngest pending value (or 0)
//   empty_o                         no pending writes
module int_rf_wb_buffer
    import int_rf_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = WB_DEPTH,
    parameter int unsigned COMMIT_W = WB_COMMIT_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic [COMMIT_W-1:0]             cm_valid_i,
    output logic                            cm_ready_o,
    input  logic [COMMIT_W*REG_IDX_LEN-1:0] cm_rd_idx_i,
    input  logic [COMMIT_W*XLEN-1:0]        cm_rd_value_i,

    output logic                            rf_valid_o,
    output logic [REG_IDX_LEN-1:0]          rf_rd_idx_o,
    output logic [XLEN-1:0]                 rf_rd_value_o,

    input  logic [REG_IDX_LEN-1:0]          issue_rs1_idx_i,
    input  logic [REG_IDX_LEN-1:0]          issue_rs2_idx_i,
    output logic                            byp_rs1_hit_o,
    output logic                            byp_rs2_hit_o,
    output logic [XLEN-1:0]                 byp_rs1_value_o,
    output logic [XLEN-1:0]                 byp_rs2_value_o,

    output logic                            empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] fifo_q;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                          pop;
    logic [CNT_W-1:0]              n_push;
    logic [COMMIT_W-1:0]           lane_we;
    logic [COMMIT_W-1:0][PTR_W-1:0] lane_slot;

    // Ready looks only at the registered count; the concurrent drain is not credited.
    assign cm_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(COMMIT_W);
    assign pop        = (count_q != '0);
    assign empty_o    = (count_q == '0);

    // Valid lanes with a non-zero destination are packed into consecutive
    // slots from the tail, preserving lane order even when lanes are sparse.
    always_comb begin
        n_push    = '0;
        lane_we   = '0;
        lane_slot = '0;
        for (int unsigned l = 0; l < COMMIT_W; l++) begin
            if (cm_ready_o && cm_valid_i[l] &&
                (cm_rd_idx_i[l*REG_IDX_LEN +: REG_IDX_LEN] != '0)) begin
                lane_we[l]   = 1'b1;
                lane_slot[l] = tail_q + n_push[PTR_W-1:0];
                n_push       = n_push + 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + n_push[PTR_W-1:0];
        count_d = count_q + n_push - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fifo_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int unsigned l = 0; l < COMMIT_W; l++) begin
                if (lane_we[l]) begin
                    fifo_q[lane_slot[l]] <= '{rd_idx: cm_rd_idx_i[l*REG_IDX_LEN +: REG_IDX_LEN],
                                              value:  cm_rd_value_i[l*XLEN +: XLEN]};
                end
            end
        end
    end

    assign rf_valid_o    = pop;
    assign rf_rd_idx_o   = fifo_q[head_q].rd_idx;
    assign rf_rd_value_o = fifo_q[head_q].value;

    // Bypass lookup: the head being written this cycle is still scanned,
    // because the RF read port returns pre-write data.
    logic [DEPTH-1:0][REG_IDX_LEN-1:0] entry_idx;
    logic [DEPTH-1:0]                  rs1_sel, rs2_sel;

    always_comb begin
        entry_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_idx[i] = fifo_q[i].rd_idx;
        end
    end

    int_rf_wb_byp_match #(
        .DEPTH (DEPTH)
    ) u_rs1_match (
        .idx_i       (issue_rs1_idx_i),
        .entry_idx_i (entry_idx),
        .head_i      (head_q),
        .count_i     (count_q),
        .sel_o       (rs1_sel)
    );

    int_rf_wb_byp_match #(
        .DEPTH (DEPTH)
    ) u_rs2_match (
        .idx_i       (issue_rs2_idx_i),
        .entry_idx_i (entry_idx),
        .head_i      (head_q),
        .count_i     (count_q),
        .sel_o       (rs2_sel)
    );

    assign byp_rs1_hit_o = |rs1_sel;
    assign byp_rs2_hit_o = |rs2_sel;

`ifdef INT_RF_WB_BYPASS_EN
    // sel is one-hot or zero, so an AND-OR mux suffices.
    always_comb begin
        byp_rs1_value_o = '0;
        byp_rs2_value_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            byp_rs1_value_o = byp_rs1_value_o | ({XLEN{rs1_sel[i]}} & fifo_q[i].value);
            byp_rs2_value_o = byp_rs2_value_o | ({XLEN{rs2_sel[i]}} & fifo_q[i].value);
        end
    end
`else
    assign byp_rs1_value_o = '0;
    assign byp_rs2_value_o = '0;
`endif

endmodule

// File: tb/tb_int_rf_wb_buffer.sv
module tb_int_rf_wb_buffer;
    import int_rf_wb_buffer_pkg::*;

    localparam int DEPTH    = 4;
    localparam int COMMIT_W = 2;
`ifdef INT_RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                            clk;
    logic                            rst_n;
    logic [COMMIT_W-1:0]             cm_valid;
    logic                            cm_ready;
    logic [COMMIT_W*REG_IDX_LEN-1:0] cm_idx;
    logic [COMMIT_W*XLEN-1:0]        cm_val;
    logic                            rf_valid;
    logic [REG_IDX_LEN-1:0]          rf_idx;
    logic [XLEN-1:0]                 rf_val;
    logic [REG_IDX_LEN-1:0]          rs1, rs2;
    logic                            hit1, hit2;
    logic [XLEN-1:0]                 bv1, bv2;
    logic                            empty;

    int n_checks = 0;
    int n_pass   = 0;

    int_rf_wb_buffer #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cm_valid_i      (cm_valid),
        .cm_ready_o      (cm_ready),
        .cm_rd_idx_i     (cm_idx),
        .cm_rd_value_i   (cm_val),
        .rf_valid_o      (rf_valid),
        .rf_rd_idx_o     (rf_idx),
        .rf_rd_value_o   (rf_val),
        .issue_rs1_idx_i (rs1),
        .issue_rs2_idx_i (rs2),
        .byp_rs1_hit_o   (hit1),
        .byp_rs2_hit_o   (hit2),
        .byp_rs1_value_o (bv1),
        .byp_rs2_value_o (bv2),
        .empty_o         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order queue of pending writes.
    typedef struct packed {
        logic [REG_IDX_LEN-1:0] idx;
        logic [XLEN-1:0]        val;
    } pend_t;
    pend_t q[$];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_lanes(input logic [1:0] v,
                             input logic [4:0] i0, input logic [XLEN-1:0] d0,
                             input logic [4:0] i1, input logic [XLEN-1:0] d1);
        cm_valid = v;
        cm_idx   = {i1, i0};
        cm_val   = {d1, d0};
    endtask

    function automatic void lookup(input logic [4:0] idx, output logic hit, output logic [XLEN-1:0] val);
        hit = 1'b0;
        val = '0;
        if (idx != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].idx == idx) begin
                    hit = 1'b1;
                    val = BYP ? q[i].val : '0;
                    break;
                end
            end
        end
    endfunction

    task automatic model_check();
        logic h;
        logic [XLEN-1:0] v;
        chk("rf_valid", {63'd0, rf_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rf_idx", {59'd0, rf_idx}, {59'd0, q[0].idx});
            chk("rf_value", rf_val, q[0].val);
        end
        lookup(rs1, h, v);
        chk("rs1_hit", {63'd0, hit1}, {63'd0, h});
        chk("rs1_value", bv1, v);
        lookup(rs2, h, v);
        chk("rs2_hit", {63'd0, hit2}, {63'd0, h});
        chk("rs2_value", bv2, v);
        chk("empty", {63'd0, empty}, {63'd0, q.size() == 0});
        chk("ready", {63'd0, cm_ready}, {63'd0, (DEPTH - q.size()) >= COMMIT_W});
    endtask

    // Applies the clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit rdy;
        rdy = (DEPTH - q.size()) >= COMMIT_W;
        if (q.size() != 0) void'(q.pop_front());
        if (rdy) begin
            for (int l = 0; l < COMMIT_W; l++) begin
                if (cm_valid[l] && cm_idx[l*5 +: 5] != 0)
                    q.push_back('{idx: cm_idx[l*5 +: 5], val: cm_val[l*XLEN +: XLEN]});
            end
        end
    endtask

    // One cycle: inputs already driven just after the previous edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic [1:0]      v;
        logic [4:0]      i0;
        logic [XLEN-1:0] d0;
        logic [4:0]      i1;
        logic [XLEN-1:0] d1;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic            e_rfv;
        logic [4:0]      e_idx;
        logic [XLEN-1:0] e_val;
        logic            e_h1;
        logic [XLEN-1:0] e_v1;
        logic            e_h2;
        logic [XLEN-1:0] e_v2;
        logic            e_empty;
        logic            e_ready;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [XLEN-1:0] b2;
        b2 = BYP ? 64'h2 : 64'h0;
        //         v     i0  d0     i1  d1     r1 r2 rfv idx val    h1 v1     h2 v2  emp rdy
        tbl[0] = '{2'b11, 5, 64'hA5, 6, 64'h5A, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1, 1};
        tbl[1] = '{2'b00, 0, 64'h0,  0, 64'h0,  0, 0, 1, 5, 64'hA5, 0, 64'h0, 0, 64'h0, 0, 1};
        tbl[2] = '{2'b00, 0, 64'h0,  0, 64'h0,  0, 0, 1, 6, 64'h5A, 0, 64'h0, 0, 64'h0, 0, 1};
        tbl[3] = '{2'b11, 0, 64'hFF, 7, 64'h11, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1, 1};
        tbl[4] = '{2'b00, 0, 64'h0,  0, 64'h0,  0, 0, 1, 7, 64'h11, 0, 64'h0, 0, 64'h0, 0, 1};
        tbl[5] = '{2'b11, 9, 64'h1,  9, 64'h2,  9, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1, 1};
        tbl[6] = '{2'b00, 0, 64'h0,  0, 64'h0,  9, 0, 1, 9, 64'h1, 1, b2,    0, 64'h0, 0, 1};
        tbl[7] = '{2'b00, 0, 64'h0,  0, 64'h0,  9, 9, 1, 9, 64'h2, 1, b2,    1, b2,    0, 1};
        tbl[8] = '{2'b00, 0, 64'h0,  0, 64'h0,  0, 9, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1, 1};
    end

    initial begin
        rst_n = 1'b0;
        rs1 = 5'd1;
        rs2 = 5'd2;
        set_lanes(2'b11, 5'd1, 64'h111, 5'd2, 64'h222);

        // Reset held with both lanes valid: nothing may be stored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_valid", {63'd0, rf_valid}, 64'd0);
        chk("rst_ready", {63'd0, cm_ready}, 64'd1);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_rs1_hit", {63'd0, hit1}, 64'd0);
        chk("rst_rs1_value", bv1, 64'd0);
        cm_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int k = 0; k < 9; k++) begin
            set_lanes(tbl[k].v, tbl[k].i0, tbl[k].d0, tbl[k].i1, tbl[k].d1);
            rs1 = tbl[k].r1;
            rs2 = tbl[k].r2;
            @(negedge clk);
            chk($sformatf("t%0d_rf_valid", k), {63'd0, rf_valid}, {63'd0, tbl[k].e_rfv});
            if (tbl[k].e_rfv) begin
                chk($sformatf("t%0d_rf_idx", k), {59'd0, rf_idx}, {59'd0, tbl[k].e_idx});
                chk($sformatf("t%0d_rf_value", k), rf_val, tbl[k].e_val);
            end
            chk($sformatf("t%0d_rs1_hit", k), {63'd0, hit1}, {63'd0, tbl[k].e_h1});
            chk($sformatf("t%0d_rs1_value", k), bv1, tbl[k].e_v1);
            chk($sformatf("t%0d_rs2_hit", k), {63'd0, hit2}, {63'd0, tbl[k].e_h2});
            chk($sformatf("t%0d_rs2_value", k), bv2, tbl[k].e_v2);
            chk($sformatf("t%0d_empty", k), {63'd0, empty}, {63'd0, tbl[k].e_empty});
            chk($sformatf("t%0d_ready", k), {63'd0, cm_ready}, {63'd0, tbl[k].e_ready});
            @(posedge clk);
            model_edge();
            #1;
        end

        // Burst: two lanes every cycle; ready must drop once three are pending.
        set_lanes(2'b11, 5'd1, 64'h10, 5'd2, 64'h20);
        cycle();
        set_lanes(2'b11, 5'd3, 64'h30, 5'd4, 64'h40);
        cycle();
        set_lanes(2'b11, 5'd5, 64'h50, 5'd6, 64'h60);
        @(negedge clk);
        chk("burst_ready_low", {63'd0, cm_ready}, 64'd0);
        chk("burst_count3_head", {59'd0, rf_idx}, 64'd2);
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        cm_valid = 2'b00;
        repeat (5) cycle();

        // Reset mid-operation with three entries queued.
        set_lanes(2'b11, 5'd11, 64'hB1, 5'd12, 64'hB2);
        cycle();
        set_lanes(2'b11, 5'd13, 64'hB3, 5'd14, 64'hB4);
        cycle();
        cm_valid = 2'b00;
        chk("pre_rst_queued", {63'd0, empty}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst_rf_valid", {63'd0, rf_valid}, 64'd0);
        chk("async_rst_empty", {63'd0, empty}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("in_rst_rf_valid", {63'd0, rf_valid}, 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();

        // Five fill/drain rounds to walk the pointers through wrap-around.
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) begin
                set_lanes(2'b11, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                                 5'($urandom_range(1, 31)), {$urandom, $urandom});
                rs1 = 5'($urandom_range(0, 31));
                rs2 = 5'($urandom_range(0, 31));
                cycle();
            end
            cm_valid = 2'b00;
            repeat (4) cycle();
        end

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            set_lanes(2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), {$urandom, $urandom},
                      5'($urandom_range(0, 7)), {$urandom, $urandom});
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            cycle();
        end
        cm_valid = 2'b00;
        repeat (5) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
